lifo_stack_ctrl: RTL and testbench
==================================

// Module: lifo_stack_ctrl
// PURPOSE
//   Parametrised LIFO stack with registered top-of-stack output, occupancy count,
//   full/empty/almost-full status and sticky, clearable overflow/underflow flags.
//   Supersedes the fixed power-of-two stack: any DEPTH >= 2, simultaneous push+pop,
//   flush, and recoverable errors (an illegal op is dropped; the stack keeps running).
//   Used wherever datapath control needs return-address or operand LIFO storage.
// PARAMETERS
//   WIDTH      11         data width in bits
//   DEPTH      128        number of entries, >= 2, need not be a power of two
//   AFULL_LVL  DEPTH-4    almost_full asserts when count >= AFULL_LVL (1..DEPTH)
//   CW         $clog2(DEPTH+1)  localparam: count width
// PORTS
//   clk          in   1      clock, rising edge
//   reset        in   1      synchronous, active-high reset
//   push         in   1      write d onto stack this cycle
//   pop          in   1      remove top entry this cycle
//   d            in   WIDTH  push data
//   flush        in   1      discard all entries (synchronous)
//   err_clr      in   1      clear overflow/underflow sticky flags
//   q            out  WIDTH  current top of stack; 0 when empty
//   q_valid      out  1      1 when stack non-empty
//   count        out  CW     number of stored entries, 0..DEPTH
//   empty        out  1      count == 0
//   full         out  1      count == DEPTH
//   almost_full  out  1      count >= AFULL_LVL
//   overflow     out  1      sticky: push attempted while full (not with pop)
//   underflow    out  1      sticky: pop attempted while empty (not with push)
// BEHAVIOUR
//   - Reset: count=0, q=0, q_valid=0, empty=1, full=0, almost_full=0 (unless
//     AFULL_LVL==0 is never legal), overflow=0, underflow=0. Storage RAM not reset.
//   - Priority per cycle: reset > flush > push/pop. All outputs registered or
//     decoded from registered count; every effect visible the cycle after the op.
//   - push only, !full: entry stored, count+1, q=d next cycle.
//   - push only, full: op dropped, state unchanged, overflow<=1.
//   - pop only, !empty: count-1; next cycle q = entry below old top, or 0 if now empty.
//   - pop only, empty: op dropped, state unchanged, underflow<=1.
//   - push+pop, !empty (incl. full): top replaced by d, count unchanged, q=d, no flag.
//   - push+pop, empty: treated as push (count=1, q=d), no underflow.
//   - flush: count=0, q=0, q_valid=0; push/pop same cycle ignored; flags untouched.
//   - err_clr: clears both sticky flags; a new error in the same cycle wins (flag=1).
//   - Flags never block operation; they only record the event until err_clr/reset.
//   - Pointer arithmetic bounded 0..DEPTH, no wrap; non-power-of-two DEPTH exact.
//   - Top held in q register; storage read of next-below entry must be ready so
//     consecutive pops every cycle sustain full throughput (1 op/cycle, no bubbles).
//   - Reset or flush mid-sequence: previous contents never reappear on q.
// TESTING
//   1 reset, then idle -> q=0, count=0, empty=1, q_valid=0, flags=0.
//   2 push 1,2,3 back-to-back, then pop x3 back-to-back -> q=1,2,3 then 2,1,0;
//     count 1,2,3,2,1,0; empty asserts on last pop's following cycle.
//   3 DEPTH=5,AFULL_LVL=4: push 5 -> almost_full at count 4, full at 5; 6th push ->
//     overflow=1, count=5, q unchanged; pop -> q=4th value; err_clr -> overflow=0.
//   4 empty, pop -> underflow=1, count=0; push 0x7FF same cycle as err_clr,
//     next cycle pop on empty again with err_clr -> underflow stays 1.
//   5 count=2 (tops A,B), push C + pop -> q=C, count=2; pop -> q=A.
//   6 count=3, flush with push -> count=0, q=0; push 0x123 -> q=0x123, count=1.

Source files
------------

// File: rtl/lifo_stack_ctrl.sv
// Parametrised LIFO stack: registered top-of-stack, occupancy count, status decode
// and sticky overflow/underflow flags. Illegal ops are dropped; the stack keeps running.
module lifo_stack_ctrl #(
    parameter int WIDTH     = 11,
    parameter int DEPTH     = 128,
    parameter int AFULL_LVL = DEPTH - 4,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] d,
    input  logic             flush,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // mem[0..count-1] holds every entry including the top; q mirrors mem[count-1]
    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    count_m1;
    logic [CW-1:0]    count_m2;
    logic             is_empty;
    logic             is_full;
    logic             op_push;
    logic             op_pop;
    logic             op_repl;
    logic             ov_evt;
    logic             un_evt;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] below;

    always_comb begin
        count_m1 = count - CW'(1);
        count_m2 = count - CW'(2);
        is_empty = (count == '0);
        is_full  = (count == CW'(DEPTH));
        op_push  = ~flush & push & (pop ? is_empty : ~is_full);
        op_pop   = ~flush & pop & ~push & ~is_empty;
        op_repl  = ~flush & push & pop & ~is_empty;
        ov_evt   = ~flush & push & ~pop & is_full;
        un_evt   = ~flush & pop & ~push & is_empty;
        wr_en    = op_push | op_repl;
        wr_addr  = op_push ? count[AW-1:0] : count_m1[AW-1:0];
        // Asynchronous read of the entry under the top keeps back-to-back pops bubble-free
        rd_addr  = (count >= CW'(2)) ? count_m2[AW-1:0] : '0;
        below    = (count >= CW'(2)) ? mem[rd_addr] : '0;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            q     <= '0;
        end else if (flush) begin
            count <= '0;
            q     <= '0;
        end else if (op_push) begin
            count <= count + CW'(1);
            q     <= d;
        end else if (op_repl) begin
            q     <= d;
        end else if (op_pop) begin
            count <= count_m1;
            q     <= below;
        end
    end

    // A new error in the same cycle as err_clr wins
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow & ~err_clr) | ov_evt;
            underflow <= (underflow & ~err_clr) | un_evt;
        end
    end

    always_comb begin
        q_valid     = ~is_empty;
        empty       = is_empty;
        full        = is_full;
        almost_full = (count >= CW'(AFULL_LVL));
    end

endmodule

// File: tb/tb_lifo_stack_ctrl.sv
// Self-checking bench for lifo_stack_ctrl: directed scenarios plus random ops,
// compared each cycle against a queue-based model of the stack.
module tb_lifo_stack_ctrl;

    localparam int W  = 11;
    localparam int D  = 5;
    localparam int AF = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk;
    logic          reset;
    logic          push;
    logic          pop;
    logic [W-1:0]  d;
    logic          flush;
    logic          err_clr;
    logic [W-1:0]  q;
    logic          q_valid;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic         m_ov;
    logic         m_un;

    lifo_stack_ctrl #(.WIDTH(W), .DEPTH(D), .AFULL_LVL(AF)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .d(d),
        .flush(flush), .err_clr(err_clr), .q(q), .q_valid(q_valid),
        .count(count), .empty(empty), .full(full), .almost_full(almost_full),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic pu, input logic po,
                              input logic [W-1:0] dv, input logic fl, input logic ec);
        logic ov_e;
        logic un_e;
        ov_e = 1'b0;
        un_e = 1'b0;
        if (r) begin
            exp_q.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            if (fl) begin
                exp_q.delete();
            end else if (pu && po) begin
                if (exp_q.size() == 0) exp_q.push_back(dv);
                else exp_q[exp_q.size()-1] = dv;
            end else if (pu) begin
                if (exp_q.size() == D) ov_e = 1'b1;
                else exp_q.push_back(dv);
            end else if (po) begin
                if (exp_q.size() == 0) un_e = 1'b1;
                else void'(exp_q.pop_back());
            end
            m_ov = (m_ov & ~ec) | ov_e;
            m_un = (m_un & ~ec) | un_e;
        end
    endtask

    task automatic check_all();
        int n;
        logic [W-1:0] top;
        n   = exp_q.size();
        top = (n == 0) ? '0 : exp_q[n-1];
        chk("q", 32'(q), 32'(top));
        chk("q_valid", 32'(q_valid), 32'(n != 0));
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == D));
        chk("almost_full", 32'(almost_full), 32'(n >= AF));
        chk("overflow", 32'(overflow), 32'(m_ov));
        chk("underflow", 32'(underflow), 32'(m_un));
    endtask

    // Drive one cycle of inputs, clock it, update the model, then check #1 after the edge
    task automatic step(input logic r, input logic pu, input logic po,
                        input logic [W-1:0] dv, input logic fl, input logic ec);
        reset   = r;
        push    = pu;
        pop     = po;
        d       = dv;
        flush   = fl;
        err_clr = ec;
        @(posedge clk);
        model_step(r, pu, po, dv, fl, ec);
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; d = '0; flush = 1'b0; err_clr = 1'b0;
        m_ov = 1'b0; m_un = 1'b0;

        // 1: reset then idle
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("reset_q", 32'(q), 32'h0);
        chk("reset_empty", 32'(empty), 32'h1);

        // 2: push 1,2,3 then pop x3
        step(0, 1, 0, 11'd1, 0, 0);
        step(0, 1, 0, 11'd2, 0, 0);
        step(0, 1, 0, 11'd3, 0, 0);
        chk("t2_top3", 32'(q), 32'd3);
        step(0, 0, 1, 0, 0, 0);
        chk("t2_pop_q2", 32'(q), 32'd2);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("t2_empty", 32'(empty), 32'h1);

        // 3: fill to full, overflow, pop, err_clr
        for (int i = 0; i < 5; i++) step(0, 1, 0, 11'(16'h10 + i), 0, 0);
        chk("t3_full", 32'(full), 32'h1);
        step(0, 1, 0, 11'h7AA, 0, 0);
        chk("t3_ovf", 32'(overflow), 32'h1);
        chk("t3_q_kept", 32'(q), 32'h14);
        step(0, 0, 1, 0, 0, 0);
        chk("t3_pop_q", 32'(q), 32'h13);
        step(0, 0, 0, 0, 0, 1);
        chk("t3_clr", 32'(overflow), 32'h0);
        step(0, 0, 0, 0, 1, 0);

        // 4: underflow, err_clr with push, pop back to empty, pop empty with err_clr
        step(0, 0, 1, 0, 0, 0);
        chk("t4_unf", 32'(underflow), 32'h1);
        step(0, 1, 0, 11'h7FF, 0, 1);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1);
        chk("t4_unf_wins", 32'(underflow), 32'h1);
        step(0, 1, 1, 11'h055, 0, 1);

        // 5: replace top with push+pop
        step(0, 1, 0, 11'h0BB, 0, 0);
        step(0, 1, 1, 11'h0CC, 0, 0);
        chk("t5_repl", 32'(q), 32'h0CC);
        step(0, 0, 1, 0, 0, 0);
        chk("t5_below", 32'(q), 32'h055);

        // 6: flush with push ignored, then fresh push
        step(0, 1, 0, 11'h0DD, 0, 0);
        step(0, 1, 0, 11'h0EE, 1, 0);
        chk("t6_flush_cnt", 32'(count), 32'h0);
        step(0, 1, 0, 11'h123, 0, 0);
        chk("t6_push", 32'(q), 32'h123);

        // Random ops, with occasional flush and mid-sequence reset
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            step(r < 2, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                 11'($urandom), r >= 2 && r < 5, $urandom_range(0, 99) < 10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
